// File: rtl/rns_modaddsub_pipe.sv
// Two-stage streaming RNS modular add/sub/neg/pass unit with valid/ready flow
// control, polynomial beat counting, out_last tagging and a sticky framing error.

`ifndef q_BASIS_LEN
`define q_BASIS_LEN 2
`endif
`ifndef q_BASIS
`define q_BASIS {32'd4294967279, 32'd4294967291}
`endif
`ifndef N_SLOTS
`define N_SLOTS 4096
`endif

module rns_modaddsub_pipe #(
   parameter int LANES = 4,
   parameter int N_LIMBS = `q_BASIS_LEN,
   parameter int WORD_W = 32,
   parameter logic [N_LIMBS-1:0][WORD_W-1:0] Q = `q_BASIS,
   parameter int BEATS = `N_SLOTS / LANES
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [1:0]                        in_op,
   input  logic [LANES*N_LIMBS*WORD_W-1:0]   in_a,
   input  logic [LANES*N_LIMBS*WORD_W-1:0]   in_b,
   input  logic                              in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [LANES*N_LIMBS*WORD_W-1:0]   out_data,
   output logic                              out_last,
   output logic                              frame_err
);

   localparam int DW = LANES * N_LIMBS * WORD_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_NEG  = 2'b10,
      OP_PASS = 2'b11
   } op_e;

   logic             s1_v;
   op_e              s1_op;
   logic [DW-1:0]    s1_a;
   logic [DW-1:0]    s1_b;
   logic             s1_last;
   logic             s2_v;
   logic [DW-1:0]    s2_data;
   logic             s2_last;
   logic [DW-1:0]    next_data;
   logic [CNT_W-1:0] beat_cnt;
   logic             frame_err_q;
   logic             s2_adv;
   logic             accept;
   logic             at_last;

   // One residue: all arithmetic is done one bit wider than a word so the
   // carry of a+b and the borrow of a-b are never lost before reduction.
   function automatic logic [WORD_W-1:0] reduce(input op_e op,
                                                input logic [WORD_W-1:0] a,
                                                input logic [WORD_W-1:0] b,
                                                input logic [WORD_W-1:0] q);
      logic [WORD_W:0] ax;
      logic [WORD_W:0] bx;
      logic [WORD_W:0] qx;
      logic [WORD_W:0] sum;
      logic [WORD_W:0] diff;
      ax   = {1'b0, a};
      bx   = {1'b0, b};
      qx   = {1'b0, q};
      sum  = ax + bx;
      diff = ax - bx;
      case (op)
         OP_ADD:  reduce = WORD_W'((sum >= qx) ? sum - qx : sum);
         OP_SUB:  reduce = WORD_W'((a >= b) ? diff : diff + qx);
         OP_NEG:  reduce = (a == '0) ? '0 : WORD_W'(qx - ax);
         default: reduce = a;
      endcase
   endfunction

   assign s2_adv   = !s2_v || out_ready;
   assign in_ready = !s1_v || s2_adv;
   assign accept   = in_valid && in_ready;
   assign at_last  = (beat_cnt == LAST_BEAT);

   // Stage 1 reloads whenever it is empty or its beat moves into stage 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_op   <= OP_ADD;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_last <= 1'b0;
      end else if (in_ready) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_op   <= op_e'(in_op);
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_last <= at_last;
         end
      end
   end

   // The counter free-runs on accepted beats; in_last is only compared, never used to resync.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt    <= '0;
         frame_err_q <= 1'b0;
      end else if (accept) begin
         beat_cnt <= at_last ? '0 : beat_cnt + CNT_W'(1);
         if (in_last != at_last) begin
            frame_err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      next_data = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int j = 0; j < N_LIMBS; j++) begin
            next_data[(l*N_LIMBS+j)*WORD_W +: WORD_W] =
               reduce(s1_op, s1_a[(l*N_LIMBS+j)*WORD_W +: WORD_W],
                      s1_b[(l*N_LIMBS+j)*WORD_W +: WORD_W], Q[j]);
         end
      end
   end

   // Stage 2 holds its result until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v    <= 1'b0;
         s2_data <= '0;
         s2_last <= 1'b0;
      end else if (s2_adv) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_data <= next_data;
            s2_last <= s1_last;
         end
      end
   end

   assign out_valid = s2_v;
   assign out_data  = s2_data;
   assign out_last  = s2_last;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rns_modaddsub_pipe.sv
// Scoreboard bench for rns_modaddsub_pipe: random and directed beats are scored
// against a plain modular-arithmetic model with framing tracked by beat count.

module tb_rns_modaddsub_pipe;

   localparam int LANES = 2;
   localparam int N_LIMBS = 2;
   localparam int WORD_W = 8;
   localparam int BEATS = 4;
   localparam int DW = LANES * N_LIMBS * WORD_W;
   localparam logic [N_LIMBS-1:0][WORD_W-1:0] Q = {8'd17, 8'd97};

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_op;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          frame_err;

   int            qv[N_LIMBS] = '{97, 17};
   exp_t          sb[$];
   exp_t          monE;
   int            nChecks = 0;
   int            nPass = 0;
   int            accCount = 0;
   int            cyc = 0;
   int            rdyMode = 0;
   bit            expFrameErr = 0;
   bit            stalled = 0;
   logic [DW-1:0] heldData;
   logic          heldLast;

   rns_modaddsub_pipe #(
      .LANES(LANES), .N_LIMBS(N_LIMBS), .WORD_W(WORD_W), .Q(Q), .BEATS(BEATS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Consumer: always ready, random, or stalled.
   always @(posedge clk) begin
      #2;
      case (rdyMode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(1, 0));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] modelResult(input logic [1:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
      logic [DW-1:0] r;
      int idx, av, bv, q, res;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int j = 0; j < N_LIMBS; j++) begin
            idx = l * N_LIMBS + j;
            av = int'(a[idx*WORD_W +: WORD_W]);
            bv = int'(b[idx*WORD_W +: WORD_W]);
            q = qv[j];
            case (op)
               2'b00:   res = (av + bv) % q;
               2'b01:   res = (av - bv + q) % q;
               2'b10:   res = (q - av) % q;
               default: res = av;
            endcase
            r[idx*WORD_W +: WORD_W] = res[WORD_W-1:0];
         end
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] pk(input int x0, input int x1);
      return {WORD_W'(x1), WORD_W'(x0), WORD_W'(x1), WORD_W'(x0)};
   endfunction

   function automatic logic [DW-1:0] randOperand();
      logic [DW-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++)
         for (int j = 0; j < N_LIMBS; j++)
            r[(l*N_LIMBS+j)*WORD_W +: WORD_W] = WORD_W'($urandom_range(qv[j] - 1, 0));
      return r;
   endfunction

   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic applyStimulus(input logic [1:0] op, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input bit corrupt);
      bit acc;
      bit lastPos;
      int budget;
      exp_t e;
      acc = 0;
      budget = 0;
      lastPos = ((accCount % BEATS) == BEATS - 1);
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      in_last = corrupt ? !lastPos : lastPos;
      while (!acc && budget < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         budget++;
         if (acc) begin
            e.data = modelResult(op, a, b);
            e.last = lastPos;
            sb.push_back(e);
            accCount++;
            if (corrupt) expFrameErr = 1'b1;
         end
         #1;
      end
      if (!acc) checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic randBeat();
      applyStimulus(2'($urandom_range(3, 0)), randOperand(), randOperand(), 1'b0);
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 200) begin
         @(posedge clk);
         #1;
         b++;
      end
      checkOutput("drain", sb.size(), 0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_frame_err", frame_err, 0);
      sb.delete();
      accCount = 0;
      expFrameErr = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks flow control.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 0;
      end else begin
         checkOutput("frame_err", frame_err, expFrameErr);
         checkOutput("in_ready", in_ready, (sb.size() < 2) || out_ready);
         if (stalled) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_data", out_data, heldData);
            checkOutput("hold_last", out_last, heldLast);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_out", out_valid, 0);
            end else begin
               monE = sb.pop_front();
               checkOutput("out_data", out_data, monE.data);
               checkOutput("out_last", out_last, monE.last);
            end
         end
         stalled = out_valid && !out_ready;
         heldData = out_data;
         heldLast = out_last;
      end
   end

   initial begin
      int t0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_op = 2'b00;
      in_a = '0;
      in_b = '0;
      in_last = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      doReset();

      $display("[TB] directed add/sub/neg/pass");
      applyStimulus(2'b00, pk(96, 16), pk(1, 1), 1'b0);
      applyStimulus(2'b00, pk(50, 8), pk(40, 8), 1'b0);
      applyStimulus(2'b00, pk(60, 9), pk(60, 9), 1'b0);
      applyStimulus(2'b01, pk(3, 2), pk(5, 2), 1'b0);
      applyStimulus(2'b10, pk(0, 5), randOperand(), 1'b0);
      applyStimulus(2'b11, pk(42, 7), randOperand(), 1'b0);
      drain();

      $display("[TB] streaming");
      doReset();
      t0 = cyc;
      for (int i = 0; i < 8; i++) randBeat();
      checkOutput("stream_cycles", cyc - t0, 8);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("stream_drained", sb.size(), 0);

      $display("[TB] backpressure");
      fork
         begin
            for (int i = 0; i < 40; i++) randBeat();
         end
         begin
            repeat (6) @(posedge clk);
            rdyMode = 2;
            repeat (3) @(negedge clk);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_out_valid", out_valid, 1);
            @(posedge clk);
            rdyMode = 1;
         end
      join
      drain();
      rdyMode = 0;

      $display("[TB] framing error");
      doReset();
      for (int i = 0; i < 8; i++)
         applyStimulus(2'($urandom_range(3, 0)), randOperand(), randOperand(), i == 1);
      drain();
      checkOutput("frame_err_sticky", frame_err, 1);

      $display("[TB] reset mid-stream");
      rdyMode = 2;
      @(posedge clk);
      #1;
      randBeat();
      randBeat();
      checkOutput("full_out_valid", out_valid, 1);
      checkOutput("full_in_ready", in_ready, 0);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", out_valid, 0);
      sb.delete();
      accCount = 0;
      expFrameErr = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdyMode = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) randBeat();
      drain();
      checkOutput("post_rst_frame_err", frame_err, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
